bcd_ascii_sender: RTL and testbench



---
 rtl/bcd_ascii_sender.sv | 145 ++++++++++++++
 tb/tb_bcd_ascii_sender.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_ascii_sender.sv
// Packed BCD word to ASCII decimal text with optional leading-zero blanking
// and a CR LF terminator, sent over a valid/ready byte stream.
module bcd_ascii_sender #(
    parameter int DIGITS   = 10,
    parameter int BCD_W    = 40,
    parameter bit BLANK_LZ = 1'b1,
    parameter bit TERM_EN  = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             bcd_vld,
    input  logic [BCD_W-1:0] Bcd_data,
    output logic [7:0]       tx_data,
    output logic             tx_vld,
    input  logic             tx_rdy,
    output logic             busy,
    output logic             done,
    output logic             drop
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        SEND,
        CR,
        LF
    } state_t;

    state_t             state_q;
    logic [BCD_W-1:0]   word_q;
    logic [IW-1:0]      idx_q;
    logic [3:0]         dig_q;
    logic               dv_q;
    logic [7:0]         tx_data_q;
    logic               tx_vld_q;
    logic               busy_q;
    logic               done_q;
    logic               drop_q;

    logic [3:0]         nib_cur;
    logic [3:0]         nib_nxt;
    logic               hs;

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    // Digit at the current index and the one below it
    always_comb begin
        nib_cur = '0;
        nib_nxt = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i))
                nib_cur = word_q[4*i +: 4];
            if (idx_q == IW'(i + 1))
                nib_nxt = word_q[4*i +: 4];
        end
    end

    assign hs = tx_vld_q && tx_rdy;

    // SKIP works on a registered digit, so its first cycle only loads dig_q
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            word_q    <= '0;
            idx_q     <= '0;
            dig_q     <= '0;
            dv_q      <= 1'b0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            drop_q <= bcd_vld && busy_q;
            unique case (state_q)
                IDLE: begin
                    if (bcd_vld) begin
                        word_q  <= Bcd_data;
                        idx_q   <= IW'(DIGITS - 1);
                        dv_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SKIP;
                    end
                end
                SKIP: begin
                    if (!dv_q) begin
                        dig_q <= nib_cur;
                        dv_q  <= 1'b1;
                    end else if (BLANK_LZ && dig_q == 4'd0
                                 && idx_q != '0) begin
                        idx_q <= idx_q - IW'(1);
                        dig_q <= nib_nxt;
                    end else begin
                        tx_data_q <= to_ascii(dig_q);
                        tx_vld_q  <= 1'b1;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (idx_q != '0) begin
                            idx_q     <= idx_q - IW'(1);
                            tx_data_q <= to_ascii(nib_nxt);
                        end else if (TERM_EN) begin
                            tx_data_q <= 8'h0D;
                            state_q   <= CR;
                        end else begin
                            tx_vld_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= IDLE;
                        end
                    end
                end
                CR: begin
                    if (hs) begin
                        tx_data_q <= 8'h0A;
                        state_q   <= LF;
                    end
                end
                LF: begin
                    if (hs) begin
                        tx_vld_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data = tx_data_q;
    assign tx_vld  = tx_vld_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign drop    = drop_q;

endmodule

// File: tb/tb_bcd_ascii_sender.sv
// Scoreboard bench for bcd_ascii_sender: blanking and non-blanking
// instances, backpressure, busy drop and mid-stream reset.
module tb_bcd_ascii_sender;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        v1 = 1'b0;
    logic        v2 = 1'b0;
    logic [39:0] Bcd_data = '0;
    logic        tx_rdy = 1'b1;
    bit          sel = 1'b0;

    logic [7:0] tx_data1, tx_data2;
    logic       tx_vld1, tx_vld2;
    logic       busy1, busy2;
    logic       done1, done2;
    logic       drop1, drop2;

    logic [7:0] tx_data_m;
    logic       tx_vld_m, busy_m, done_m, drop_m, bcd_vld_m;

    exp_t sb[$];
    int   latq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   cap = 0;
    int   acc = 0;

    bcd_ascii_sender dut (
        .Clk(Clk), .Rst_n(Rst_n), .bcd_vld(v1), .Bcd_data(Bcd_data),
        .tx_data(tx_data1), .tx_vld(tx_vld1), .tx_rdy(tx_rdy),
        .busy(busy1), .done(done1), .drop(drop1)
    );

    bcd_ascii_sender #(.BLANK_LZ(1'b0)) dut_nz (
        .Clk(Clk), .Rst_n(Rst_n), .bcd_vld(v2), .Bcd_data(Bcd_data),
        .tx_data(tx_data2), .tx_vld(tx_vld2), .tx_rdy(tx_rdy),
        .busy(busy2), .done(done2), .drop(drop2)
    );

    assign tx_data_m = sel ? tx_data2 : tx_data1;
    assign tx_vld_m  = sel ? tx_vld2  : tx_vld1;
    assign busy_m    = sel ? busy2    : busy1;
    assign done_m    = sel ? done2    : done1;
    assign drop_m    = sel ? drop2    : drop1;
    assign bcd_vld_m = sel ? v2       : v1;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Expected text plus CR LF; the LF byte closes the word
    task automatic expect_str(input string s, input int lat);
        exp_t e;
        for (int i = 0; i < s.len(); i++) begin
            e.b = s[i];
            e.last = 1'b0;
            sb.push_back(e);
        end
        e.b = 8'h0D; e.last = 1'b0; sb.push_back(e);
        e.b = 8'h0A; e.last = 1'b1; sb.push_back(e);
        latq.push_back(lat);
    endtask

    // Monitor: all output checks against the scoreboard
    bit         prev_v = 1'b0;
    bit         hold_v = 1'b0;
    logic [7:0] hold_d = '0;
    bit         done_exp = 1'b0;
    always @(negedge Clk) begin
        if (!Rst_n) begin
            prev_v   = 1'b0;
            hold_v   = 1'b0;
            done_exp = 1'b0;
        end else begin
            if (done_m || done_exp)
                chk("done", int'(done_m), int'(done_exp));
            done_exp = 1'b0;
            if (tx_vld_m && !prev_v) begin
                if (latq.size() == 0)
                    chk("lat_unexpected", 1, 0);
                else
                    chk("latency", cyc - cap, latq.pop_front());
            end
            prev_v = tx_vld_m;
            if (bcd_vld_m && !busy_m)
                cap = cyc + 1;
            if (tx_vld_m) begin
                if (hold_v)
                    chk("held_data", int'(tx_data_m), int'(hold_d));
                hold_v = !tx_rdy;
                hold_d = tx_data_m;
            end else begin
                hold_v = 1'b0;
            end
            if (tx_vld_m && tx_rdy) begin
                acc++;
                if (sb.size() == 0) begin
                    chk("extra_byte", int'(tx_data_m), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("byte", int'(tx_data_m), int'(e.b));
                    done_exp = e.last;
                end
            end
        end
    end

    task automatic start_word(input logic [39:0] d);
        Bcd_data = d;
        if (sel) v2 = 1'b1;
        else     v1 = 1'b1;
        @(posedge Clk);
        #1;
        v1 = 1'b0;
        v2 = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_m && n < 300) begin
            @(posedge Clk);
            #1;
            n++;
        end
        if (busy_m)
            chk("idle_timeout", 1, 0);
        repeat (2) @(posedge Clk);
        #1;
        chk("sb_left", sb.size(), 0);
        chk("lat_left", latq.size(), 0);
    endtask

    task automatic run_word(input logic [39:0] d, input string s,
                            input int lat);
        expect_str(s, lat);
        start_word(d);
        wait_idle();
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_tx_data", int'(tx_data1), 0);
        chk("rst_tx_vld", int'(tx_vld1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_done", int'(done1), 0);
        chk("rst_drop", int'(drop1), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        run_word(40'h0000001234, "1234", 8);
        run_word(40'h0000000000, "0", 11);
        run_word(40'h9876543210, "9876543210", 2);

        sel = 1'b1;
        run_word(40'h0000000042, "0000000042", 2);
        sel = 1'b0;

        // Backpressure: long stall, then alternating ready
        expect_str("57", 10);
        tx_rdy = 1'b0;
        fork
            start_word(40'h0000000057);
            begin
                repeat (14) @(posedge Clk);
                for (int k = 0; k < 100 && busy1; k++) begin
                    #1 tx_rdy = (k % 2 == 0);
                    @(posedge Clk);
                end
            end
        join
        wait_idle();
        tx_rdy = 1'b1;

        // Second word while busy is dropped
        expect_str("99", 10);
        start_word(40'h0000000099);
        repeat (3) @(posedge Clk);
        #1;
        Bcd_data = 40'h0000000055;
        v1 = 1'b1;
        @(posedge Clk);
        #1;
        v1 = 1'b0;
        @(negedge Clk);
        chk("drop_pulse", int'(drop1), 1);
        @(negedge Clk);
        chk("drop_clear", int'(drop1), 0);
        wait_idle();

        run_word(40'h000000000A, "?", 11);

        // Reset after the second byte of a stream
        begin
            int base = acc;
            int n = 0;
            expect_str("1234", 8);
            start_word(40'h0000001234);
            while (acc < base + 2 && n < 100) begin
                @(negedge Clk);
                n++;
            end
            if (acc < base + 2)
                chk("rst_wait_timeout", 1, 0);
            @(posedge Clk);
            #2 Rst_n = 1'b0;
            #1;
            chk("mid_rst_tx_vld", int'(tx_vld1), 0);
            chk("mid_rst_busy", int'(busy1), 0);
            sb.delete();
            latq.delete();
            repeat (2) @(negedge Clk);
            Rst_n = 1'b1;
            repeat (3) @(posedge Clk);
            #1;
            chk("post_rst_done", int'(done1), 0);
        end

        run_word(40'h0000000007, "7", 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
